// File: rtl/fec_tb_encoder_if.sv
// Serial bit-stream interface of the tail-biting encoder.
// The PRBS side and the interleaver side are grouped into one bundle.
interface fec_tb_encoder_if;
  logic data_in;
  logic valid_in;
  logic ready_fec;
  logic data_out;
  logic valid_out;
  logic ready_in;

  modport slave (
    input  data_in,
    input  valid_in,
    input  ready_in,
    output ready_fec,
    output data_out,
    output valid_out
  );

  modport master (
    output data_in,
    output valid_in,
    output ready_in,
    input  ready_fec,
    input  data_out,
    input  valid_out
  );
endinterface

// File: rtl/fec_tb_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder (G1=171 -> X, G2=133 -> Y)
// with two-bank ping-pong block buffering and a registered output stage.
module fec_tb_encoder #(
  parameter int unsigned BLOCK_BITS = 96,
  parameter int unsigned CNT_W      = 8
) (
  input logic            clk,
  input logic            reset_N,
  fec_tb_encoder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BLOCK_BITS);

  typedef enum logic [1:0] {BkEmpty, BkFull, BkReading} bank_st_e;
  typedef enum logic [1:0] {StIdle, StLoad, StEncode} state_e;

  logic [BLOCK_BITS-1:0] bank_q [2];
  bank_st_e              bank_st_q [2];
  bank_st_e              bank_st_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  state_e                state_q, state_d;
  logic [6:1]            s_q, s_d;
  logic                  phase_q, phase_d;
  logic                  dout_q, dout_d;
  logic                  vout_q, vout_d;

  logic                  in_fire;
  logic                  out_fire;
  logic                  can_load;
  logic [BLOCK_BITS-1:0] rd_bank;
  logic [6:1]            s_load;
  logic                  u;
  logic                  x_bit;
  logic                  y_bit;
  logic                  x0_bit;

  assign bus.ready_fec = reset_N && (bank_st_q[wr_ptr_q] == BkEmpty);
  assign bus.data_out  = dout_q;
  assign bus.valid_out = vout_q;

  assign in_fire  = bus.valid_in && bus.ready_fec;
  assign out_fire = vout_q && bus.ready_in;
  assign can_load = !vout_q || bus.ready_in;

  assign rd_bank = bank_q[rd_ptr_q];
  assign u       = rd_bank[rd_cnt_q[IDX_W-1:0]];
  assign x_bit   = u ^ s_q[1] ^ s_q[2] ^ s_q[3] ^ s_q[6];
  assign y_bit   = u ^ s_q[2] ^ s_q[3] ^ s_q[5] ^ s_q[6];

  // Tail-biting start state: s1 = last bit of the block, s6 = b[N-6].
  always_comb begin
    s_load = '0;
    for (int k = 1; k <= 6; k++) begin
      s_load[k] = rd_bank[BLOCK_BITS-k];
    end
  end

  // X for b0 is emitted from the LOAD cycle so the first bit appears two cycles after capture.
  assign x0_bit = rd_bank[0] ^ s_load[1] ^ s_load[2] ^ s_load[3] ^ s_load[6];

  always_ff @(posedge clk) begin
    if (in_fire) begin
      bank_q[wr_ptr_q][wr_cnt_q[IDX_W-1:0]] <= bus.data_in;
    end
  end

  always_comb begin
    bank_st_d = bank_st_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    state_d   = state_q;
    s_d       = s_q;
    phase_d   = phase_q;
    dout_d    = dout_q;
    vout_d    = vout_q;

    if (in_fire) begin
      if (wr_cnt_q == CNT_W'(BLOCK_BITS - 1)) begin
        wr_cnt_d            = '0;
        bank_st_d[wr_ptr_q] = BkFull;
        wr_ptr_d            = ~wr_ptr_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bank_st_q[rd_ptr_q] == BkFull) begin
          bank_st_d[rd_ptr_q] = BkReading;
          state_d             = StLoad;
        end
      end
      StLoad: begin
        s_d      = s_load;
        rd_cnt_d = '0;
        dout_d   = x0_bit;
        vout_d   = 1'b1;
        phase_d  = 1'b1;
        state_d  = StEncode;
      end
      StEncode: begin
        if (rd_cnt_q == CNT_W'(BLOCK_BITS)) begin
          // All bits staged; release the bank once the final Y leaves the output register.
          if (out_fire) begin
            vout_d              = 1'b0;
            bank_st_d[rd_ptr_q] = BkEmpty;
            rd_ptr_d            = ~rd_ptr_q;
            if (bank_st_q[~rd_ptr_q] == BkFull) begin
              bank_st_d[~rd_ptr_q] = BkReading;
              state_d              = StLoad;
            end else begin
              state_d = StIdle;
            end
          end
        end else if (can_load) begin
          vout_d = 1'b1;
          if (!phase_q) begin
            dout_d  = x_bit;
            phase_d = 1'b1;
          end else begin
            dout_d   = y_bit;
            phase_d  = 1'b0;
            s_d      = {s_q[5:1], u};
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      bank_st_q[0] <= BkEmpty;
      bank_st_q[1] <= BkEmpty;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      state_q      <= StIdle;
      s_q          <= '0;
      phase_q      <= 1'b0;
      dout_q       <= 1'b0;
      vout_q       <= 1'b0;
    end else begin
      bank_st_q <= bank_st_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      state_q   <= state_d;
      s_q       <= s_d;
      phase_q   <= phase_d;
      dout_q    <= dout_d;
      vout_q    <= vout_d;
    end
  end

endmodule

// File: tb/tb_fec_tb_encoder.sv
// Directed bench for the tail-biting encoder: fixed patterns, impulses,
// back-to-back random blocks under output backpressure, and mid-block reset.
module tb_fec_tb_encoder;

  localparam int N  = 96;
  localparam int N2 = 2 * N;

  logic clk;
  logic reset_N;
  int   checks;
  int   errors;
  logic got[$];
  int   stall_seen;
  int   stall_viol;
  logic prev_stall;
  logic prev_data;

  fec_tb_encoder_if bus ();

  fec_tb_encoder #(.BLOCK_BITS(N), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every output handshake and watch data/valid stability while stalled.
  always @(negedge clk) begin
    if (reset_N) begin
      if (prev_stall) begin
        stall_seen <= stall_seen + 1;
        if (!bus.valid_out || bus.data_out !== prev_data) stall_viol <= stall_viol + 1;
      end
      if (bus.valid_out && bus.ready_in) got.push_back(bus.data_out);
      prev_stall <= bus.valid_out && !bus.ready_in;
      prev_data  <= bus.data_out;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  function automatic logic [N2-1:0] ref_enc(input logic [N-1:0] b);
    logic [N2-1:0] r;
    logic [6:1]    s;
    logic          uu;
    r = '0;
    for (int k = 1; k <= 6; k++) s[k] = b[N-k];
    for (int i = 0; i < N; i++) begin
      uu         = b[i];
      r[2*i]     = uu ^ s[1] ^ s[2] ^ s[3] ^ s[6];
      r[2*i + 1] = uu ^ s[2] ^ s[3] ^ s[5] ^ s[6];
      s          = {s[5:1], uu};
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_block();
    logic [N-1:0] b;
    b = {$urandom(), $urandom(), $urandom()};
    return b;
  endfunction

  task automatic send_bits(input logic [N-1:0] blk, input int nbits, output int waits);
    int t;
    waits = 0;
    for (int i = 0; i < nbits; i++) begin
      bus.data_in  = blk[i];
      bus.valid_in = 1'b1;
      t = 0;
      while (!bus.ready_fec && t < 2000) begin
        @(posedge clk); #1;
        t++;
        waits++;
      end
      if (t >= 2000) begin
        checks++; errors++;
        $display("FAIL send_timeout bit %0d: ready_fec stayed 0, required 1", i);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (got.size() < n && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (got.size() < n) begin
      checks++; errors++;
      $display("FAIL out_timeout: got %0d bits, required %0d", got.size(), n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [N2-1:0] got_block(input int base);
    logic [N2-1:0] v;
    v = '0;
    for (int i = 0; i < N2; i++) if (base + i < got.size()) v[i] = got[base + i];
    return v;
  endfunction

  task automatic check_block(input string name, input int base, input logic [N2-1:0] exp);
    logic [N2-1:0] act;
    act = got_block(base);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_count(input string name, input int exp);
    checks++;
    if (got.size() != exp) begin
      errors++;
      $display("FAIL %s: got %0d output bits, required %0d", name, got.size(), exp);
    end
  endtask

  task automatic test_reset();
    reset_N = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready_fec !== 1'b0) begin
      errors++; $display("FAIL reset_ready_fec: got %b required 0", bus.ready_fec);
    end
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid_out: got %b required 0", bus.valid_out);
    end
    checks++;
    if (bus.data_out !== 1'b0) begin
      errors++; $display("FAIL reset_data_out: got %b required 0", bus.data_out);
    end
    reset_N = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.ready_fec !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready_fec: got %b required 1", bus.ready_fec);
    end
  endtask

  task automatic test_all_zero();
    int w;
    int cyc;
    got.delete();
    bus.ready_in = 1'b1;
    send_bits('0, N, w);
    bus.valid_in = 1'b0;
    cyc = 0;
    while (!bus.valid_out && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 2) begin
      errors++; $display("FAIL zero_latency: got %0d cycles required 2", cyc);
    end
    wait_outputs(N2);
    check_count("zero_count", N2);
    check_block("zero_data", 0, '0);
  endtask

  task automatic test_all_ones();
    int w;
    got.delete();
    bus.ready_in = 1'b1;
    send_bits('1, N, w);
    bus.valid_in = 1'b0;
    wait_outputs(N2);
    check_count("ones_count", N2);
    check_block("ones_data", 0, '1);
  endtask

  task automatic test_impulse_first();
    int            w;
    logic [N-1:0]  blk;
    logic [13:0]   pre;
    logic [N2-1:0] exp;
    pre = 14'b11_10_11_11_00_01_11;
    exp = '0;
    for (int i = 0; i < 14; i++) exp[i] = pre[13-i];
    blk    = '0;
    blk[0] = 1'b1;
    got.delete();
    bus.ready_in = 1'b1;
    send_bits(blk, N, w);
    bus.valid_in = 1'b0;
    wait_outputs(N2);
    check_block("impulse_b0_hand", 0, exp);
    check_block("impulse_b0_ref", 0, ref_enc(blk));
  endtask

  task automatic test_tail_bite();
    int            w;
    logic [N-1:0]  blk;
    logic [11:0]   pre;
    logic [N2-1:0] exp;
    pre = 12'b10_11_11_00_01_11;
    exp = '0;
    for (int i = 0; i < 12; i++) exp[i] = pre[11-i];
    exp[N2-2] = 1'b1;
    exp[N2-1] = 1'b1;
    blk       = '0;
    blk[N-1]  = 1'b1;
    got.delete();
    bus.ready_in = 1'b1;
    send_bits(blk, N, w);
    bus.valid_in = 1'b0;
    wait_outputs(N2);
    check_block("tail_b95_hand", 0, exp);
    checks++;
    if (dut.s_q !== 6'b000001) begin
      errors++; $display("FAIL tail_final_state: got %b required 000001", dut.s_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] blks [4];
    int           waits_total;
    int           w;
    int           t;
    for (int b = 0; b < 4; b++) blks[b] = rand_block();
    got.delete();
    stall_seen  = 0;
    stall_viol  = 0;
    waits_total = 0;
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          send_bits(blks[b], N, w);
          waits_total += w;
        end
        bus.valid_in = 1'b0;
      end
      begin
        t = 0;
        while (got.size() < 4 * N2 && t < 20000) begin
          @(posedge clk); #1;
          bus.ready_in = ($urandom_range(0, 3) != 0);
          t++;
        end
        bus.ready_in = 1'b1;
      end
    join
    wait_outputs(4 * N2);
    check_count("b2b_count", 4 * N2);
    for (int b = 0; b < 4; b++) check_block($sformatf("b2b_block%0d", b), b * N2, ref_enc(blks[b]));
    checks++;
    if (waits_total == 0) begin
      errors++; $display("FAIL b2b_backpressure: ready_fec low cycles %0d, required > 0", waits_total);
    end
    checks++;
    if (stall_seen == 0 || stall_viol != 0) begin
      errors++;
      $display("FAIL b2b_stall_hold: stalls %0d unstable %0d, required >0 and 0", stall_seen, stall_viol);
    end
  endtask

  task automatic test_reset_mid();
    int           w;
    logic [N-1:0] blk_c;
    bus.ready_in = 1'b1;
    got.delete();
    send_bits(rand_block(), N, w);
    send_bits(rand_block(), N / 2, w);
    reset_N = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.ready_fec !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: valid_out %b ready_fec %b, required 0 0",
               bus.valid_out, bus.ready_fec);
    end
    bus.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_N = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.ready_fec !== 1'b1 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: ready_fec %b valid_out %b, required 1 0",
               bus.ready_fec, bus.valid_out);
    end
    got.delete();
    blk_c = rand_block();
    send_bits(blk_c, N, w);
    bus.valid_in = 1'b0;
    wait_outputs(N2);
    repeat (20) @(posedge clk);
    #1;
    check_count("midreset_count", N2);
    check_block("midreset_data", 0, ref_enc(blk_c));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    stall_seen   = 0;
    stall_viol   = 0;
    prev_stall   = 1'b0;
    prev_data    = 1'b0;
    reset_N      = 1'b0;
    bus.data_in  = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    test_reset();
    test_all_zero();
    test_all_ones();
    test_impulse_first();
    test_tail_bite();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fec_tb_encoder.md
Name: fec_tb_encoder

Overview:
Rate-1/2 tail-biting convolutional encoder (K=7, G1=171 octal -> X, G2=133 octal -> Y) per IEEE 802.16 OFDMA FEC. It consumes the serial randomized stream from the PRBS randomizer in 96-bit blocks and emits 192 coded bits per block, serialized X then Y, to the interleaver. Two-bank ping-pong buffering lets block k+1 be captured while block k is encoded.

Parameters:
BLOCK_BITS, 96, uncoded bits per block (>= 7).
CNT_W, 8, width of bit/output counters; must satisfy 2^CNT_W > 2*BLOCK_BITS.

Ports:
clk  in  1  rising-edge clock
reset_N  in  1  asynchronous active-low reset
data_in  in  1  randomized bit from PRBS
valid_in  in  1  data_in valid (from PRBS valid_out)
ready_fec  out  1  encoder can accept data_in this cycle (to PRBS ready_fec)
data_out  out  1  coded bit to interleaver
valid_out  out  1  data_out valid
ready_in  in  1  interleaver can accept data_out

Behaviour:
- Input handshake: bit accepted on rising edge where valid_in && ready_fec. Bits stored in write bank at index wr_cnt (b0 = first bit of block); wr_cnt increments 0..BLOCK_BITS-1 then wraps to 0, bank marked FULL, write pointer toggles to other bank.
- ready_fec = 1 iff current write bank is EMPTY; forced 0 while reset_N low. Deasserts in the cycle after filling a bank if the other bank is still FULL/being read.
- Bank states: EMPTY -> FULL (last bit written) -> READING (claimed by read FSM) -> EMPTY (last coded bit handshaken out). A bank is never written while FULL/READING.
- Read FSM states: IDLE, LOAD, ENCODE.
  IDLE: if read bank FULL -> LOAD.
  LOAD (1 cycle): shift register s[1..6] <= {b[N-1], b[N-2], ..., b[N-6]} (s1 = last bit of block, s6 = b[N-6]), N=BLOCK_BITS; rd_cnt <= 0, phase <= X -> ENCODE.
  ENCODE: u = b[rd_cnt]; X = u^s1^s2^s3^s6; Y = u^s2^s3^s5^s6. Emit X, then Y, one bit per output handshake. After Y accepted: s <= {u, s1..s5}, rd_cnt++. After Y of bit N-1 accepted: bank -> EMPTY, read pointer toggles, -> IDLE (or straight to LOAD if other bank FULL; one LOAD cycle always inserted between blocks).
- Output: data_out/valid_out registered. While valid_out && !ready_in, data_out and valid_out hold stable; no bit dropped or repeated. valid_out may not depend combinationally on ready_in.
- Latency: with ready_in=1, valid_out first rises 2 cycles after the edge capturing b[N-1] (one IDLE->LOAD, one LOAD). Steady state with ready_in held 1: 2*N consecutive valid cycles per block, 1 idle cycle between blocks.
- Throughput: input rate capped at 1 bit per 2 cycles long-term; ready_fec backpressure enforces it.
- Tail-biting check: after last bit of block, s[1..6] equals value loaded in LOAD (assertion in bench).
- Simultaneous events: write completing a bank and read releasing the other bank in the same cycle are both honoured; ready_fec reflects new state next cycle.
- Reset (any time, incl. mid-block): both banks EMPTY, wr_cnt=rd_cnt=0, FSM IDLE, s=0, valid_out=0, data_out=0; partial/in-flight blocks discarded. Bank contents need no reset.

Test Plan:
1. All-zero block of 96 bits, ready_in=1 -> 192 output bits all 0; valid_out rises 2 cycles after 96th input handshake.
2. All-ones block -> 192 output bits all 1 (initial state 111111, both taps sets odd weight).
3. b0=1, rest 0 -> output begins 11 10 11 11 00 01 11, remaining 178 bits 0.
4. b95=1, rest 0 (tail-biting) -> output begins 10 11 11 00 01 11, then zeros, final pair (for b95) = 11; final state == loaded state.
5. Back-to-back 4 random blocks with valid_in=1, random ready_in toggling -> output matches software reference encoder bit-exactly; ready_fec drops while both banks occupied; data_out held stable during every stall.
6. Assert reset_N low mid-way through encoding block 1 with block 2 half captured -> valid_out=0, ready_fec=0 during reset, =1 after release; next full block encodes correctly with no residue.
